// File: rtl/pc_gen.sv
// Program-counter generator at the head of fetch: prioritised trap/redirect/stall
// selection, sequential increment and a circular return-address stack for return prediction.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_stall,
    input  logic                       i_redirect_en,
    input  logic [XLEN-1:0]            i_redirect_pc,
    input  logic                       i_trap_en,
    input  logic [XLEN-1:0]            i_trap_vec,
    input  logic                       i_call,
    input  logic                       i_ret,
    output logic [XLEN-1:0]            o_pc,
    output logic [XLEN-1:0]            o_pc_plus4,
    output logic                       o_ras_hit,
    output logic                       o_misalign,
    output logic [$clog2(RAS_DEPTH):0] o_ras_count
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            ras_hit_q, ras_hit_d;
    logic            misalign_q, misalign_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   top_q, top_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [XLEN-1:0] pc_plus4;
    logic            ras_nonempty;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign ras_nonempty = (count_q != '0);

    always_comb begin
        pc_d       = pc_plus4;
        ras_hit_d  = 1'b0;
        misalign_d = 1'b0;
        count_d    = count_q;
        top_d      = top_q;
        ras_d      = ras_q;

        if (i_trap_en) begin
            pc_d       = {i_trap_vec[XLEN-1:2], 2'b00};
            misalign_d = |i_trap_vec[1:0];
            count_d    = '0;
            top_d      = '0;
        end else if (i_redirect_en) begin
            pc_d       = {i_redirect_pc[XLEN-1:2], 2'b00};
            misalign_d = |i_redirect_pc[1:0];
        end else if (i_stall) begin
            pc_d = pc_q;
        end else if (i_ret && ras_nonempty) begin
            pc_d      = ras_q[top_q];
            ras_hit_d = 1'b1;
            if (i_call) begin
                // Call+ret pair: the popped slot is reused for the new return address.
                ras_d[top_q] = pc_plus4;
            end else begin
                top_d   = top_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end else if (i_call) begin
            // When full, top+1 lands on the oldest entry, so it is overwritten.
            top_d        = top_q + PW'(1);
            ras_d[top_d] = pc_plus4;
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            ras_hit_q  <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            top_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            ras_hit_q  <= ras_hit_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
            top_q      <= top_d;
        end
    end

    // Stack contents need no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign o_pc        = pc_q;
    assign o_pc_plus4  = pc_plus4;
    assign o_ras_hit   = ras_hit_q;
    assign o_misalign  = misalign_q;
    assign o_ras_count = count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_pc_gen;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        i_stall;
    logic        i_redirect_en;
    logic [31:0] i_redirect_pc;
    logic        i_trap_en;
    logic [31:0] i_trap_vec;
    logic        i_call;
    logic        i_ret;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_ras_hit;
    logic        o_misalign;
    logic [2:0]  o_ras_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc;
    bit          m_hit;
    bit          m_mis;
    logic [31:0] m_ras[$];

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_stall(i_stall),
        .i_redirect_en(i_redirect_en),
        .i_redirect_pc(i_redirect_pc),
        .i_trap_en(i_trap_en),
        .i_trap_vec(i_trap_vec),
        .i_call(i_call),
        .i_ret(i_ret),
        .o_pc(o_pc),
        .o_pc_plus4(o_pc_plus4),
        .o_ras_hit(o_ras_hit),
        .o_misalign(o_misalign),
        .o_ras_count(o_ras_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_hit = 1'b0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Driver: applies one cycle of inputs and advances the model at the same edge.
    task automatic step(input bit trap, input logic [31:0] tvec, input bit redir,
                        input logic [31:0] rpc, input bit stall, input bit call, input bit ret);
        logic [31:0] npc;
        bit          nhit;
        bit          nmis;
        logic [31:0] ras_n[$];
        i_trap_en     = trap;
        i_trap_vec    = tvec;
        i_redirect_en = redir;
        i_redirect_pc = rpc;
        i_stall       = stall;
        i_call        = call;
        i_ret         = ret;
        ras_n = m_ras;
        npc   = m_pc + 32'd4;
        nhit  = 1'b0;
        nmis  = 1'b0;
        if (trap) begin
            npc  = tvec & ~32'h3;
            nmis = (tvec[1:0] != 2'b00);
            ras_n.delete();
        end else if (redir) begin
            npc  = rpc & ~32'h3;
            nmis = (rpc[1:0] != 2'b00);
        end else if (stall) begin
            npc = m_pc;
        end else if (ret && ras_n.size() > 0) begin
            npc  = ras_n[ras_n.size()-1];
            nhit = 1'b1;
            if (call) ras_n[ras_n.size()-1] = m_pc + 32'd4;
            else void'(ras_n.pop_back());
        end else if (call) begin
            ras_n.push_back(m_pc + 32'd4);
            if (ras_n.size() > DEPTH) void'(ras_n.pop_front());
        end
        @(posedge clk);
        m_pc  = npc;
        m_hit = nhit;
        m_mis = nmis;
        m_ras = ras_n;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input logic [31:0] a);
        step(0, 0, 1, a, 0, 0, 0);
    endtask

    // Scoreboard: compares every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", o_pc, m_pc);
            chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
            chk("ras_hit", {31'b0, o_ras_hit}, {31'b0, m_hit});
            chk("misalign", {31'b0, o_misalign}, {31'b0, m_mis});
            chk("ras_count", {29'b0, o_ras_count}, 32'(m_ras.size()));
        end
    end

    initial begin
        rst = 1'b1;
        step_inputs_zero();
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_pc", o_pc, 32'h1000);
        chk("lit_reset_count", {29'b0, o_ras_count}, 32'd0);
        chk("lit_reset_hit", {31'b0, o_ras_hit}, 32'd0);
        chk("lit_reset_mis", {31'b0, o_misalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        idle(); chk("lit_free1", o_pc, 32'h1004);
        idle(); chk("lit_free2", o_pc, 32'h1008);
        idle(); chk("lit_free3", o_pc, 32'h100C);

        // Async reset in the middle of operation with a non-empty stack
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("lit_pre_rst_count", {29'b0, o_ras_count}, 32'd2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("lit_midrst_pc", o_pc, 32'h1000);
        chk("lit_midrst_count", {29'b0, o_ras_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stall and stall overridden by redirect
        redirect(32'h20);                  chk("lit_redir20", o_pc, 32'h20);
        step(0, 0, 0, 0, 1, 0, 0);         chk("lit_stall1", o_pc, 32'h20);
        step(0, 0, 0, 0, 1, 1, 1);         chk("lit_stall2", o_pc, 32'h20);
        step(0, 0, 1, 32'h80, 1, 0, 0);    chk("lit_stall_redir", o_pc, 32'h80);

        // Trap beats redirect and clears the stack; misaligned redirect
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h100, 1, 32'h200, 0, 1, 0);
        chk("lit_trap_pc", o_pc, 32'h100);
        chk("lit_trap_count", {29'b0, o_ras_count}, 32'd0);
        redirect(32'h203);
        chk("lit_mis_pc", o_pc, 32'h200);
        chk("lit_mis_on", {31'b0, o_misalign}, 32'd1);
        idle();
        chk("lit_mis_off", {31'b0, o_misalign}, 32'd0);
        chk("lit_mis_next", o_pc, 32'h204);

        // Call / redirect / return
        redirect(32'h10);
        step(0, 0, 0, 0, 0, 1, 0);
        redirect(32'h400);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("lit_ret_pc", o_pc, 32'h14);
        chk("lit_ret_hit", {31'b0, o_ras_hit}, 32'd1);
        chk("lit_ret_count", {29'b0, o_ras_count}, 32'd0);

        // Overflow: five calls into a four-deep stack
        for (int k = 0; k < 5; k++) begin
            redirect(32'(k) * 32'h10);
            step(0, 0, 0, 0, 0, 1, 0);
        end
        chk("lit_full_count", {29'b0, o_ras_count}, 32'd4);
        step(0, 0, 0, 0, 0, 0, 1); chk("lit_pop1", o_pc, 32'h44);
        step(0, 0, 0, 0, 0, 0, 1); chk("lit_pop2", o_pc, 32'h34);
        step(0, 0, 0, 0, 0, 0, 1); chk("lit_pop3", o_pc, 32'h24);
        step(0, 0, 0, 0, 0, 0, 1); chk("lit_pop4", o_pc, 32'h14);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("lit_pop5_pc", o_pc, 32'h18);
        chk("lit_pop5_hit", {31'b0, o_ras_hit}, 32'd0);

        // Wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        chk("lit_wrap_plus4", o_pc_plus4, 32'h0);
        idle();
        chk("lit_wrap_pc", o_pc, 32'h0);

        // Simultaneous call and return with one entry
        step(1, 32'h4C, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        redirect(32'h60);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("lit_cr_pc", o_pc, 32'h50);
        chk("lit_cr_count", {29'b0, o_ras_count}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("lit_cr_top", o_pc, 32'h64);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
            b = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
            step($urandom_range(0, 15) == 0, a, $urandom_range(0, 7) == 0, b,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic step_inputs_zero();
        i_stall       = 1'b0;
        i_redirect_en = 1'b0;
        i_redirect_pc = '0;
        i_trap_en     = 1'b0;
        i_trap_vec    = '0;
        i_call        = 1'b0;
        i_ret         = 1'b0;
    endtask

endmodule
